edsac_run_sequencer: RTL and testbench

- Drives the control-switches unit from the machine side.
- Generates the digit timing pulses d18/d35 and the order end pulse ep.
- Generates the machine-side stop sources starter_neg, c22 and s2, plus the single-step completion pulse sep2.
- Consumes the panel-derived start, stop_neg, epsep and ep11, and sits between the control-switches unit and the main control/order decoder.

---
 rtl/edsac_timing_pkg.sv | 19 +
 rtl/edsac_digit_timer.sv | 52 +++++
 rtl/edsac_run_sequencer.sv | 169 ++++++++++++++++
 tb/tb_edsac_run_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edsac_timing_pkg.sv
// Shared timing types and digit constants for the EDSAC run sequencer.
package edsac_timing_pkg;

  localparam int WORD_DIGITS_DEF = 36;
  localparam int D18             = 18;

  typedef enum logic [2:0] {
    STOPPED  = 3'd0,
    STARTING = 3'd1,
    RUN      = 3'd2,
    STEP     = 3'd3,
    WAIT_ACK = 3'd4
  } run_state_t;

  function automatic logic order_active(input run_state_t s);
    return (s == RUN) || (s == STEP);
  endfunction

endpackage

// File: rtl/edsac_digit_timer.sv
// Free-running digit counter with word counter and d18/d35 decode.
module edsac_digit_timer
  import edsac_timing_pkg::*;
#(
  parameter int WORD_DIGITS = WORD_DIGITS_DEF,
  parameter int ORDER_WORDS = 4,
  parameter int DIG_W       = $clog2(WORD_DIGITS),
  parameter int WRD_W       = (ORDER_WORDS > 1) ? $clog2(ORDER_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrd_clr_i,
  output logic [DIG_W-1:0] dig_o,
  output logic [WRD_W-1:0] wrd_o,
  output logic             d18_o,
  output logic             d35_o
);

  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(WORD_DIGITS - 1);
  localparam logic [DIG_W-1:0] DIG_18   = DIG_W'(D18);
  localparam logic [WRD_W-1:0] WRD_LAST = WRD_W'(ORDER_WORDS - 1);

  logic [DIG_W-1:0] dig_q, dig_d;
  logic [WRD_W-1:0] wrd_q, wrd_d;

  always_comb begin
    dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    wrd_d = wrd_q;
    // Entry clear wins over the d35 increment so a new order always starts at word 0.
    if (wrd_clr_i) begin
      wrd_d = '0;
    end else if (dig_q == DIG_LAST) begin
      wrd_d = (wrd_q == WRD_LAST) ? '0 : wrd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q <= '0;
      wrd_q <= '0;
    end else begin
      dig_q <= dig_d;
      wrd_q <= wrd_d;
    end
  end

  assign dig_o = dig_q;
  assign wrd_o = wrd_q;
  assign d18_o = (dig_q == DIG_18);
  assign d35_o = (dig_q == DIG_LAST);

endmodule

// File: rtl/edsac_run_sequencer.sv
// Machine-side run sequencer: digit timing, order end pulse and stop sources.
// Optional order counter output enabled by EDSAC_RUN_SEQUENCER_ORDER_COUNT_EN.
//
// state    | meaning
// STOPPED  | idle, waiting for start or a single-step request
// STARTING | starter_neg held low for STARTER_WORDS full words
// RUN      | continuous order cycles, ep every ORDER_WORDS words
// STEP     | one order cycle for single-step
// WAIT_ACK | waiting for ep11 before reporting sep2
module edsac_run_sequencer
  import edsac_timing_pkg::*;
#(
  parameter int WORD_DIGITS   = WORD_DIGITS_DEF,
  parameter int ORDER_WORDS   = 4,
  parameter int STARTER_WORDS = 8,
  parameter int CHECK_DIGIT   = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop_neg,
  input  logic        epsep,
  input  logic        ep11,
  input  logic        stop_order,
  input  logic        check_fail,
  output logic        d18,
  output logic        d35,
  output logic        ep,
  output logic        starter_neg,
  output logic        s2,
  output logic        c22,
  output logic        sep2,
  output logic        running
`ifdef EDSAC_RUN_SEQUENCER_ORDER_COUNT_EN
  ,
  output logic [15:0] order_count
`endif
);

  localparam int DIG_W = $clog2(WORD_DIGITS);
  localparam int WRD_W = (ORDER_WORDS > 1) ? $clog2(ORDER_WORDS) : 1;
  localparam int STR_W = $clog2(STARTER_WORDS + 2);
  localparam int TMO_W = $clog2(2 * WORD_DIGITS);

  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(WORD_DIGITS - 1);
  localparam logic [DIG_W-1:0] CHK_DIG  = DIG_W'(CHECK_DIGIT);
  localparam logic [WRD_W-1:0] WRD_LAST = WRD_W'(ORDER_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(2 * WORD_DIGITS - 1);

  logic [DIG_W-1:0] dig;
  logic [WRD_W-1:0] wrd;
  logic             d18_w, d35_w, wrd_clr;

  run_state_t       state_q, state_d;
  logic [STR_W-1:0] str_q, str_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             chk_q, chk_d;
  logic             sep2_q, sep2_d;
  logic             c22_w, ep_w, s2_w;

  edsac_digit_timer #(
    .WORD_DIGITS (WORD_DIGITS),
    .ORDER_WORDS (ORDER_WORDS),
    .DIG_W       (DIG_W),
    .WRD_W       (WRD_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrd_clr_i (wrd_clr),
    .dig_o     (dig),
    .wrd_o     (wrd),
    .d18_o     (d18_w),
    .d35_o     (d35_w)
  );

  assign c22_w   = chk_q && (state_q != STOPPED) && (dig == CHK_DIG);
  assign ep_w    = order_active(state_q) && d35_w && (wrd == WRD_LAST) && !c22_w;
  assign s2_w    = ep_w && (state_q == RUN) && stop_order;
  assign wrd_clr = (state_d != state_q) && ((state_d == RUN) || (state_d == STEP));

  always_comb begin
    state_d = state_q;
    str_d   = str_q;
    tmo_d   = tmo_q;
    sep2_d  = 1'b0;
    chk_d   = (state_q == STOPPED || c22_w) ? 1'b0 : (chk_q | check_fail);
    if (c22_w) begin
      state_d = STOPPED;
    end else if (start && (state_q != STARTING)) begin
      state_d = STARTING;
      // A partial first word adds one extra d35 before the full words begin.
      str_d   = (dig == DIG_LAST) ? STR_W'(STARTER_WORDS) : STR_W'(STARTER_WORDS + 1);
    end else begin
      unique case (state_q)
        STOPPED: begin
          if (epsep && !stop_neg) state_d = STEP;
        end
        STARTING: begin
          if (d35_w) begin
            if (str_q == STR_W'(1)) state_d = RUN;
            else                    str_d   = str_q - 1'b1;
          end
        end
        RUN: begin
          if (ep_w && (stop_order || !stop_neg)) state_d = STOPPED;
        end
        STEP: begin
          if (ep_w) begin
            state_d = WAIT_ACK;
            tmo_d   = TMO_LAST;
          end
        end
        WAIT_ACK: begin
          if (ep11) begin
            sep2_d  = 1'b1;
            state_d = STOPPED;
          end else if (tmo_q == '0) begin
            state_d = STOPPED;
          end else begin
            tmo_d = tmo_q - 1'b1;
          end
        end
        default: state_d = STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STOPPED;
      str_q   <= '0;
      tmo_q   <= '0;
      chk_q   <= 1'b0;
      sep2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      str_q   <= str_d;
      tmo_q   <= tmo_d;
      chk_q   <= chk_d;
      sep2_q  <= sep2_d;
    end
  end

  assign d18         = d18_w;
  assign d35         = d35_w;
  assign ep          = ep_w;
  assign s2          = s2_w;
  assign c22         = c22_w;
  assign sep2        = sep2_q;
  assign starter_neg = (state_q != STARTING);
  assign running     = (state_q == RUN);

`ifdef EDSAC_RUN_SEQUENCER_ORDER_COUNT_EN
  logic [15:0] ocnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocnt_q <= '0;
    end else if ((state_d == STARTING) && (state_q != STARTING)) begin
      ocnt_q <= '0;
    end else if (ep_w) begin
      ocnt_q <= ocnt_q + 16'd1;
    end
  end

  assign order_count = ocnt_q;
`endif

endmodule

// File: tb/tb_edsac_run_sequencer.sv
// Bench for edsac_run_sequencer: directed table, corner sequences, random vs timestamp model.
module tb_edsac_run_sequencer;

  localparam int WD = 36;
  localparam int OW = 4;
  localparam int SW = 8;
  localparam int CD = 22;

  localparam int M_STOP  = 0;
  localparam int M_START = 1;
  localparam int M_RUN   = 2;
  localparam int M_STEP  = 3;
  localparam int M_WAIT  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, stop_neg = 1'b1, epsep = 1'b0, ep11 = 1'b0;
  logic stop_order = 1'b0, check_fail = 1'b0;
  logic d18, d35, ep, starter_neg, s2, c22, sep2, running;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  edsac_run_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop_neg    (stop_neg),
    .epsep       (epsep),
    .ep11        (ep11),
    .stop_order  (stop_order),
    .check_fail  (check_fail),
    .d18         (d18),
    .d35         (d35),
    .ep          (ep),
    .starter_neg (starter_neg),
    .s2          (s2),
    .c22         (c22),
    .sep2        (sep2),
    .running     (running)
  );

  // Reference model: absolute cycle timestamps since reset release.
  int t, mode, entry_t, start_end, wait_entry, sep2_t;
  bit chk;
  bit e_d18, e_d35, e_ep, e_sn, e_s2, e_c22, e_sep2, e_run;
  logic c_d18, c_d35, c_ep, c_sn, c_s2, c_c22, c_sep2, c_run;

  typedef struct {
    int at_t;
    bit start;
    bit epsep;
    bit stop_order;
    bit x_d18, x_d35, x_ep, x_sn, x_s2, x_run;
  } vec_t;

  vec_t tbl[14];

  task automatic chk1(input string name, input logic act, input bit exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d got %b expected %b", name, t, act, exp);
    end
  endtask

  task automatic model_outputs();
    int dg;
    int n35;
    dg     = t % WD;
    e_d18  = (dg == 18);
    e_d35  = (dg == WD - 1);
    e_run  = (mode == M_RUN);
    e_sn   = (mode != M_START);
    e_c22  = (mode != M_STOP) && chk && (dg == CD);
    e_ep   = 1'b0;
    if ((mode == M_RUN || mode == M_STEP) && dg == WD - 1) begin
      n35  = (t - entry_t - (WD - 1 - entry_t % WD)) / WD + 1;
      e_ep = (n35 % OW == 0) && !e_c22;
    end
    e_s2   = e_ep && (mode == M_RUN) && stop_order;
    e_sep2 = (sep2_t == t);
  endtask

  task automatic model_update();
    int e;
    bit nchk;
    nchk = (mode == M_STOP || e_c22) ? 1'b0 : (chk | check_fail);
    if (e_c22) begin
      mode = M_STOP;
    end else if (start && mode != M_START) begin
      mode      = M_START;
      entry_t   = t + 1;
      e         = entry_t % WD;
      start_end = entry_t + (WD - 1 - e) + WD * (SW - ((e == 0) ? 1 : 0));
    end else begin
      case (mode)
        M_STOP:  if (epsep && !stop_neg) begin mode = M_STEP; entry_t = t + 1; end
        M_START: if (t == start_end) begin mode = M_RUN; entry_t = t + 1; end
        M_RUN:   if (e_ep && (stop_order || !stop_neg)) mode = M_STOP;
        M_STEP:  if (e_ep) begin mode = M_WAIT; wait_entry = t + 1; end
        M_WAIT: begin
          if (ep11) begin
            sep2_t = t + 1;
            mode   = M_STOP;
          end else if (t - wait_entry == 2 * WD - 1) begin
            mode = M_STOP;
          end
        end
        default: mode = M_STOP;
      endcase
    end
    chk = nchk;
  endtask

  task automatic cyc();
    @(negedge clk);
    model_outputs();
    c_d18 = d18; c_d35 = d35; c_ep = ep; c_sn = starter_neg;
    c_s2 = s2; c_c22 = c22; c_sep2 = sep2; c_run = running;
    chk1("d18", c_d18, e_d18);
    chk1("d35", c_d35, e_d35);
    chk1("ep", c_ep, e_ep);
    chk1("starter_neg", c_sn, e_sn);
    chk1("s2", c_s2, e_s2);
    chk1("c22", c_c22, e_c22);
    chk1("sep2", c_sep2, e_sep2);
    chk1("running", c_run, e_run);
    model_update();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk1("rst_d18", d18, 1'b0);
    chk1("rst_d35", d35, 1'b0);
    chk1("rst_ep", ep, 1'b0);
    chk1("rst_starter_neg", starter_neg, 1'b1);
    chk1("rst_s2", s2, 1'b0);
    chk1("rst_c22", c22, 1'b0);
    chk1("rst_sep2", sep2, 1'b0);
    chk1("rst_running", running, 1'b0);
    t = 0; mode = M_STOP; chk = 1'b0; sep2_t = -1;
    entry_t = 0; wait_entry = 0; start_end = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0d got timeout expected finish", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int nsep;
    //             at   st ep so  d18 d35 ep sn s2 run
    tbl[0]  = '{   0,  0, 0, 0,  0,  0,  0, 1, 0, 0};
    tbl[1]  = '{  18,  0, 0, 0,  1,  0,  0, 1, 0, 0};
    tbl[2]  = '{  35,  0, 0, 0,  0,  1,  0, 1, 0, 0};
    tbl[3]  = '{  54,  0, 0, 0,  1,  0,  0, 1, 0, 0};
    tbl[4]  = '{  71,  0, 0, 0,  0,  1,  0, 1, 0, 0};
    tbl[5]  = '{  77,  1, 0, 0,  0,  0,  0, 1, 0, 0};
    tbl[6]  = '{  78,  0, 0, 0,  0,  0,  0, 0, 0, 0};
    tbl[7]  = '{ 395,  0, 0, 0,  0,  1,  0, 0, 0, 0};
    tbl[8]  = '{ 396,  0, 0, 0,  0,  0,  0, 1, 0, 1};
    tbl[9]  = '{ 539,  0, 0, 0,  0,  1,  1, 1, 0, 1};
    tbl[10] = '{ 540,  0, 0, 0,  0,  0,  0, 1, 0, 1};
    tbl[11] = '{ 683,  0, 0, 1,  0,  1,  1, 1, 1, 1};
    tbl[12] = '{ 684,  0, 0, 0,  0,  0,  0, 1, 0, 0};
    tbl[13] = '{ 827,  0, 0, 0,  0,  1,  0, 1, 0, 0};

    #2;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      run_to(tbl[i].at_t);
      start = tbl[i].start; epsep = tbl[i].epsep; stop_order = tbl[i].stop_order;
      cyc();
      start = 1'b0; epsep = 1'b0; stop_order = 1'b0;
      chk1("tbl_d18", c_d18, tbl[i].x_d18);
      chk1("tbl_d35", c_d35, tbl[i].x_d35);
      chk1("tbl_ep", c_ep, tbl[i].x_ep);
      chk1("tbl_starter_neg", c_sn, tbl[i].x_sn);
      chk1("tbl_s2", c_s2, tbl[i].x_s2);
      chk1("tbl_running", c_run, tbl[i].x_run);
    end

    // Single step with acknowledge, then single step that times out.
    do_reset();
    run_to(10);
    stop_neg = 1'b0; epsep = 1'b1; cyc(); epsep = 1'b0;
    run_to(143); cyc();
    chk1("step_ep", c_ep, 1'b1);
    run_to(146);
    ep11 = 1'b1; cyc(); ep11 = 1'b0;
    cyc();
    chk1("step_sep2", c_sep2, 1'b1);
    run_to(150);
    epsep = 1'b1; cyc(); epsep = 1'b0;
    run_to(287); cyc();
    chk1("step2_ep", c_ep, 1'b1);
    run_to(360);
    epsep = 1'b1; cyc(); epsep = 1'b0;
    run_to(503); cyc();
    chk1("timeout_restep_ep", c_ep, 1'b1);
    run_to(520);
    stop_neg = 1'b1;

    // Check failure in RUN aborts the order at digit 22.
    do_reset();
    run_to(5);
    start = 1'b1; cyc(); start = 1'b0;
    run_to(334);
    check_fail = 1'b1; cyc(); check_fail = 1'b0;
    run_to(346); cyc();
    chk1("c22_pulse", c_c22, 1'b1);
    cyc();
    chk1("c22_stopped", c_run, 1'b0);
    run_to(467); cyc();
    chk1("c22_no_ep", c_ep, 1'b0);

    // Reset in STEP, then reset with sep2 just registered.
    do_reset();
    stop_neg = 1'b0;
    run_to(3);
    epsep = 1'b1; cyc(); epsep = 1'b0;
    run_to(100);
    do_reset();
    nsep = 0;
    for (int i = 0; i < 200; i++) begin
      ep11 = (i % 7 == 3);
      cyc();
      if (c_sep2 === 1'b1) nsep++;
    end
    ep11 = 1'b0;
    chk1("rst_no_sep2", (nsep != 0), 1'b0);
    do_reset();
    run_to(3);
    epsep = 1'b1; cyc(); epsep = 1'b0;
    run_to(143); cyc();
    chk1("rst2_ep", c_ep, 1'b1);
    run_to(145);
    ep11 = 1'b1; cyc(); ep11 = 1'b0;
    do_reset();
    stop_neg = 1'b1;

    // Random stimulus against the model.
    for (int i = 0; i < 8000; i++) begin
      start      = ($urandom_range(0, 299) == 0);
      epsep      = ($urandom_range(0, 59) == 0);
      ep11       = ($urandom_range(0, 29) == 0);
      check_fail = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) stop_neg = ~stop_neg;
      if ($urandom_range(0, 9) == 0) stop_order = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3999) == 0) do_reset();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
